instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit.sv | 106 ++++++++++
 tb/tb_instr_fetch_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch and PC sequencer: fetches one word over a busywait handshake,
// holds it for decode/execute, then steps the PC by +4 or a signed word offset.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 8
) (
  input  logic               CLK,
  input  logic               RESETN,
  output logic               IMEM_READ,
  output logic [IMEM_AW-1:0] IMEM_ADDR,
  input  logic               IMEM_BUSYWAIT,
  input  logic [31:0]        IMEM_INSTR,
  input  logic               J,
  input  logic               BEQ,
  input  logic               BNEQ,
  input  logic               ZERO,
  input  logic               STALL,
  output logic [31:0]        PC,
  output logic [31:0]        INSTRUCTION,
  output logic [7:0]         OPCODE,
  output logic [7:0]         DEST,
  output logic [7:0]         SRC1,
  output logic [7:0]         SRC2,
  output logic               VALID,
  output logic [15:0]        RETIRED
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t      state, state_next;
  logic        latch_instr;
  logic        retire;
  logic        take_target;
  logic [31:0] pc_plus4;
  logic [31:0] pc_target;
  logic [31:0] pc_next;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    IMEM_READ   = 1'b0;
    latch_instr = 1'b0;
    retire      = 1'b0;
    unique case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        IMEM_READ = 1'b1;
        if (!IMEM_BUSYWAIT) begin
          latch_instr = 1'b1;
          state_next  = EXEC;
        end
      end
      EXEC: begin
        if (!STALL) begin
          retire     = 1'b1;
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // J, BEQ-taken and BNEQ-taken all select the same target, so their
  // priority order cannot change the outcome.
  always_comb begin
    pc_plus4    = PC + 32'd4;
    pc_target   = pc_plus4 + {{22{DEST[7]}}, DEST, 2'b00};
    take_target = J | (BEQ & ZERO) | (BNEQ & ~ZERO);
    pc_next     = take_target ? pc_target : pc_plus4;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state       <= IDLE;
      PC          <= RESET_PC;
      INSTRUCTION <= 32'h0;
      VALID       <= 1'b0;
      RETIRED     <= 16'h0;
    end else begin
      state <= state_next;
      if (latch_instr) begin
        INSTRUCTION <= IMEM_INSTR;
        VALID       <= 1'b1;
      end
      if (retire) begin
        PC      <= pc_next;
        VALID   <= 1'b0;
        RETIRED <= RETIRED + 16'd1;
      end
    end
  end

  assign IMEM_ADDR = PC[IMEM_AW+1:2];
  assign OPCODE    = INSTRUCTION[31:24];
  assign DEST      = INSTRUCTION[23:16];
  assign SRC1      = INSTRUCTION[15:8];
  assign SRC2      = INSTRUCTION[7:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed and randomized instruction
// sequences checked against a transaction-level PC/instruction model.
module tb_instr_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic        IMEM_BUSYWAIT, J, BEQ, BNEQ, ZERO, STALL;
  logic [31:0] IMEM_INSTR;

  logic        IMEM_READ, VALID;
  logic [7:0]  IMEM_ADDR, OPCODE, DEST, SRC1, SRC2;
  logic [31:0] PC, INSTRUCTION;
  logic [15:0] RETIRED;

  logic        hi_read, hi_valid;
  logic [7:0]  hi_addr, hi_opcode, hi_dest, hi_src1, hi_src2;
  logic [31:0] hi_pc, hi_instr;
  logic [15:0] hi_retired;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_AW(8)) dut (
    .CLK(CLK), .RESETN(RESETN), .IMEM_READ(IMEM_READ), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .IMEM_INSTR(IMEM_INSTR), .J(J), .BEQ(BEQ),
    .BNEQ(BNEQ), .ZERO(ZERO), .STALL(STALL), .PC(PC), .INSTRUCTION(INSTRUCTION),
    .OPCODE(OPCODE), .DEST(DEST), .SRC1(SRC1), .SRC2(SRC2), .VALID(VALID),
    .RETIRED(RETIRED)
  );

  // Same stimulus, reset PC one word below zero: its PC must always trail by 4.
  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .IMEM_AW(8)) dut_hi (
    .CLK(CLK), .RESETN(RESETN), .IMEM_READ(hi_read), .IMEM_ADDR(hi_addr),
    .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .IMEM_INSTR(IMEM_INSTR), .J(J), .BEQ(BEQ),
    .BNEQ(BNEQ), .ZERO(ZERO), .STALL(STALL), .PC(hi_pc), .INSTRUCTION(hi_instr),
    .OPCODE(hi_opcode), .DEST(hi_dest), .SRC1(hi_src1), .SRC2(hi_src2),
    .VALID(hi_valid), .RETIRED(hi_retired)
  );

  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_instr;
  logic [15:0] exp_ret;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic noise_controls();
    J    = 1'($urandom_range(0, 1));
    BEQ  = 1'($urandom_range(0, 1));
    BNEQ = 1'($urandom_range(0, 1));
    ZERO = 1'($urandom_range(0, 1));
  endtask

  // Called at a falling edge while the DUT should be fetching; returns at the
  // falling edge of the next fetch cycle.
  task automatic do_instr(input int busy, input int stall, input logic [7:0] dest,
                          input logic j, input logic beq, input logic bneq,
                          input logic zero);
    logic [31:0] word;
    logic [7:0]  exp_addr;
    bit          take;
    word         = $urandom;
    word[23:16]  = dest;
    exp_addr     = exp_pc[9:2];
    for (int b = 0; b <= busy; b++) begin
      check("fetch_read", {31'h0, IMEM_READ}, 32'd1);
      check("fetch_valid", {31'h0, VALID}, 32'd0);
      check("fetch_pc", PC, exp_pc);
      check("fetch_addr", {24'h0, IMEM_ADDR}, {24'h0, exp_addr});
      check("fetch_instr_hold", INSTRUCTION, exp_instr);
      IMEM_BUSYWAIT = (b < busy);
      IMEM_INSTR    = (b < busy) ? $urandom : word;
      STALL         = 1'($urandom_range(0, 1));
      noise_controls();
      @(negedge CLK);
    end
    exp_instr = word;
    for (int s = 0; s <= stall; s++) begin
      check("exec_valid", {31'h0, VALID}, 32'd1);
      check("exec_read", {31'h0, IMEM_READ}, 32'd0);
      check("exec_instr", INSTRUCTION, word);
      check("exec_opcode", {24'h0, OPCODE}, {24'h0, word[31:24]});
      check("exec_dest", {24'h0, DEST}, {24'h0, word[23:16]});
      check("exec_src1", {24'h0, SRC1}, {24'h0, word[15:8]});
      check("exec_src2", {24'h0, SRC2}, {24'h0, word[7:0]});
      check("exec_pc", PC, exp_pc);
      check("exec_retired", {16'h0, RETIRED}, {16'h0, exp_ret});
      check("hi_pc_offset", hi_pc, exp_pc - 32'd4);
      IMEM_BUSYWAIT = 1'($urandom_range(0, 1));
      IMEM_INSTR    = $urandom;
      if (s < stall) begin
        STALL = 1'b1;
        noise_controls();
      end else begin
        STALL = 1'b0;
        J = j; BEQ = beq; BNEQ = bneq; ZERO = zero;
      end
      @(negedge CLK);
    end
    take    = j || (beq && zero) || (bneq && !zero);
    exp_pc  = exp_pc + 32'd4 + (take ? 32'(4 * int'($signed(dest))) : 32'd0);
    exp_ret = exp_ret + 16'd1;
  endtask

  initial begin
    RESETN = 1'b0; IMEM_BUSYWAIT = 1'b0; IMEM_INSTR = 32'h0;
    J = 1'b0; BEQ = 1'b0; BNEQ = 1'b0; ZERO = 1'b0; STALL = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_pc", PC, 32'h0);
    check("rst_hi_pc", hi_pc, 32'hFFFF_FFFC);
    check("rst_valid", {31'h0, VALID}, 32'd0);
    check("rst_read", {31'h0, IMEM_READ}, 32'd0);
    check("rst_retired", {16'h0, RETIRED}, 32'd0);
    check("rst_instr", INSTRUCTION, 32'h0);

    RESETN = 1'b1;
    #1;
    check("idle_read", {31'h0, IMEM_READ}, 32'd0);
    @(negedge CLK);
    exp_pc = 32'h0; exp_instr = 32'h0; exp_ret = 16'h0;

    for (int i = 0; i < 4; i++)
      do_instr(0, 0, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    check("seq_pc16", PC, 32'd16);
    check("seq_retired4", {16'h0, RETIRED}, 32'd4);
    do_instr(3, 0, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);  // 16 -> 20, slow fetch
    do_instr(0, 0, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0);         // J back: 20 -> 16
    check("jump_back_pc", PC, 32'd16);
    do_instr(0, 0, 8'h02, 1'b0, 1'b1, 1'b0, 1'b1);         // BEQ taken: -> 28
    check("beq_taken_pc", PC, 32'd28);
    do_instr(0, 0, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0);         // BEQ not taken: -> 32
    check("beq_not_taken_pc", PC, 32'd32);
    do_instr(0, 0, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);         // BNEQ taken: -> 40
    check("bneq_taken_pc", PC, 32'd40);
    do_instr(0, 0, 8'h03, 1'b1, 1'b1, 1'b0, 1'b0);         // J+BEQ: -> 56
    check("j_beq_pc", PC, 32'd56);
    do_instr(0, 0, 8'h05, 1'b0, 1'b0, 1'b1, 1'b1);         // BNEQ not taken: -> 60
    do_instr(0, 2, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);  // stalled: -> 64
    check("stall_release_pc", PC, 32'd64);
    do_instr(0, 0, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);         // wraps below zero
    check("wrap_neg_pc", PC, 32'hFFFF_FE44);

    for (int i = 0; i < 150; i++)
      do_instr($urandom_range(0, 2), $urandom_range(0, 2), 8'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    IMEM_BUSYWAIT = 1'b1;
    IMEM_INSTR    = $urandom;
    @(negedge CLK);
    check("midfetch_read", {31'h0, IMEM_READ}, 32'd1);
    RESETN = 1'b0;
    #1;
    check("arst_read", {31'h0, IMEM_READ}, 32'd0);
    check("arst_pc", PC, 32'h0);
    check("arst_hi_pc", hi_pc, 32'hFFFF_FFFC);
    check("arst_valid", {31'h0, VALID}, 32'd0);
    check("arst_instr", INSTRUCTION, 32'h0);
    check("arst_retired", {16'h0, RETIRED}, 32'd0);
    IMEM_BUSYWAIT = 1'b0;
    IMEM_INSTR    = 32'hDEAD_BEEF;
    @(negedge CLK);
    check("arst_no_latch", INSTRUCTION, 32'h0);
    RESETN = 1'b1;
    exp_pc = 32'h0; exp_instr = 32'h0; exp_ret = 16'h0;
    #1;
    check("idle2_read", {31'h0, IMEM_READ}, 32'd0);
    @(negedge CLK);
    do_instr(0, 0, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    check("hi_wrap_to_zero", hi_pc, 32'h0);
    do_instr(1, 1, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
